// File: rtl/mctrl_pkg.sv
// Shared definitions for the multicycle controller: state encodings,
// opcode/funct field values and the 4-bit ALU control codes.
package mctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;

    localparam logic [3:0] AC_AND = 4'b0000;
    localparam logic [3:0] AC_OR  = 4'b0001;
    localparam logic [3:0] AC_ADD = 4'b0010;
    localparam logic [3:0] AC_SUB = 4'b0110;
    localparam logic [3:0] AC_SLT = 4'b0111;
    localparam logic [3:0] AC_SLL = 4'b1000;
    localparam logic [3:0] AC_SRL = 4'b1001;
    localparam logic [3:0] AC_BAD = 4'b1111;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decode from ALUOp and the R-type funct field.
module alu_decoder
    import mctrl_pkg::*;
(
    input  logic [1:0] ALUOp,
    input  logic [5:0] funct,
    output logic [3:0] ALUControl
);

    // ALUOp selects add/sub directly; 10 defers to funct; 11 is unused.
    always_comb begin
        ALUControl = AC_BAD;
        case (ALUOp)
            2'b00: ALUControl = AC_ADD;
            2'b01: ALUControl = AC_SUB;
            2'b10: begin
                case (funct)
                    FN_ADD, FN_ADDU: ALUControl = AC_ADD;
                    FN_SUB, FN_SUBU: ALUControl = AC_SUB;
                    FN_AND:          ALUControl = AC_AND;
                    FN_OR:           ALUControl = AC_OR;
                    FN_SLT:          ALUControl = AC_SLT;
                    FN_SLL:          ALUControl = AC_SLL;
                    FN_SRL:          ALUControl = AC_SRL;
                    default:         ALUControl = AC_BAD;
                endcase
            end
            default: ALUControl = AC_BAD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control unit: Moore FSM, PC-enable logic and a
// retired-instruction counter. Build option MCTRL_ILLEGAL_TRAP_EN sends
// illegal opcodes to a sticky TRAP state instead of treating them as no-ops.
//
// Memory handshake: MemReady=1 means the memory finishes the access being
// requested this cycle; it is only observed in FETCH, MEMRD and MEMWR and
// the FSM holds in those states until it sees it.
module multicycle_control
    import mctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 4,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [5:0]           Opcode,
    input  logic [5:0]           funct,
    input  logic                 Zero,
    input  logic                 MemReady,
    output logic                 IorD,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 MemtoReg,
    output logic                 RegDst,
    output logic                 RegWrite,
    output logic                 ALUSrcA,
    output logic                 PCEn,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ALUOp,
    output logic [1:0]           PCSource,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic [3:0]           State,
    output logic [CNT_W-1:0]     InstrRetired,
    output logic                 Illegal
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             retire;
    logic [3:0]       alu_code;

    // State and retired-instruction counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (retire) cnt_q <= cnt_q + 1'b1;
        end
    end

    // Next-state selection; Opcode comes from the IR so it is stable after FETCH.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (MemReady) state_d = S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    OP_LW, OP_SW:   state_d = S_MEMADR;
                    OP_RTYPE:       state_d = S_EXEC;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_ADDI:        state_d = S_ADDIEX;
                    OP_J:           state_d = S_JUMP;
`ifdef MCTRL_ILLEGAL_TRAP_EN
                    default:        state_d = S_TRAP;
`else
                    default:        state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: state_d = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (MemReady) state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  if (MemReady) state_d = S_FETCH;
            S_EXEC:   state_d = S_RWB;
            S_RWB:    state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
`ifdef MCTRL_ILLEGAL_TRAP_EN
            S_TRAP:   state_d = S_TRAP;
`endif
            default:  state_d = S_FETCH;
        endcase
    end

    // An instruction retires when it completes back into FETCH; the illegal
    // no-op path from DECODE is deliberately excluded.
    always_comb begin
        retire = 1'b0;
        if (state_d == S_FETCH) begin
            case (state_q)
                S_MEMWB, S_MEMWR, S_RWB, S_BRANCH, S_JUMP, S_ADDIWB: retire = 1'b1;
                default: retire = 1'b0;
            endcase
        end
    end

    // Moore control decode, with IRWrite/PCEn qualified by MemReady and Zero.
    always_comb begin
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        MemtoReg = 1'b0;
        RegDst   = 1'b0;
        RegWrite = 1'b0;
        ALUSrcA  = 1'b0;
        PCEn     = 1'b0;
        ALUSrcB  = 2'b00;
        ALUOp    = 2'b00;
        PCSource = 2'b00;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = MemReady;
                PCEn    = MemReady;
            end
            S_DECODE: ALUSrcB = 2'b11;
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUOp    = 2'b01;
                PCSource = 2'b01;
                PCEn     = (Opcode == OP_BNE) ? ~Zero : Zero;
            end
            S_JUMP: begin
                PCSource = 2'b10;
                PCEn     = 1'b1;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_ADDIWB: RegWrite = 1'b1;
            default: ;
        endcase
    end

    alu_decoder u_alu_decoder (
        .ALUOp      (ALUOp),
        .funct      (funct),
        .ALUControl (alu_code)
    );

`ifdef MCTRL_ILLEGAL_TRAP_EN
    assign Illegal    = (state_q == S_TRAP);
    assign ALUControl = Illegal ? '0 : ALUCTRL_W'(alu_code);
`else
    assign Illegal    = 1'b0;
    assign ALUControl = ALUCTRL_W'(alu_code);
`endif

    assign State        = state_q;
    assign InstrRetired = cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: a default instance plus a
// CNT_W=4 / ALUCTRL_W=6 instance sharing the same stimulus.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  Opcode = '0;
    logic [5:0]  funct = '0;
    logic        Zero = 1'b0;
    logic        MemReady = 1'b0;

    logic        IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, PCEn;
    logic [1:0]  ALUSrcB, ALUOp, PCSource;
    logic [3:0]  ALUControl;
    logic [3:0]  State;
    logic [15:0] InstrRetired;
    logic        Illegal;

    logic        IorD4, MemRead4, MemWrite4, IRWrite4, MemtoReg4, RegDst4, RegWrite4, ALUSrcA4, PCEn4;
    logic [1:0]  ALUSrcB4, ALUOp4, PCSource4;
    logic [5:0]  ALUControl4;
    logic [3:0]  State4;
    logic [3:0]  InstrRetired4;
    logic        Illegal4;

    int          tests = 0;
    int          fails = 0;
    logic [15:0] exp_ret = '0;

    // clock / reset
    always #5 clk = ~clk;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .funct(funct), .Zero(Zero),
        .MemReady(MemReady), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .PCEn(PCEn), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .ALUControl(ALUControl), .State(State),
        .InstrRetired(InstrRetired), .Illegal(Illegal)
    );

    multicycle_control #(.ALUCTRL_W(6), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .funct(funct), .Zero(Zero),
        .MemReady(MemReady), .IorD(IorD4), .MemRead(MemRead4), .MemWrite(MemWrite4),
        .IRWrite(IRWrite4), .MemtoReg(MemtoReg4), .RegDst(RegDst4), .RegWrite(RegWrite4),
        .ALUSrcA(ALUSrcA4), .PCEn(PCEn4), .ALUSrcB(ALUSrcB4), .ALUOp(ALUOp4),
        .PCSource(PCSource4), .ALUControl(ALUControl4), .State(State4),
        .InstrRetired(InstrRetired4), .Illegal(Illegal4)
    );

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_jump();
        Opcode   = 6'b000010;
        MemReady = 1'b1;
        tick();
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        tests++;
        if (State !== 4'd0) begin fails++; $display("FAIL reset_state: got %0d want 0", State); end
        tests++;
        if (InstrRetired !== 16'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", InstrRetired); end
        tests++;
        if (Illegal !== 1'b0) begin fails++; $display("FAIL reset_illegal: got %b want 0", Illegal); end
        tests++;
        if (MemRead !== 1'b1 || ALUSrcB !== 2'b01) begin
            fails++; $display("FAIL reset_fetch_ctrl: MemRead=%b ALUSrcB=%b want 1/01", MemRead, ALUSrcB);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        exp_ret = '0;
    endtask

    task automatic test_fetch_stall();
        Opcode   = 6'b000010;
        MemReady = 1'b0;
        #1;
        tests++;
        if (IRWrite !== 1'b0 || PCEn !== 1'b0) begin
            fails++; $display("FAIL stall_ctrl: IRWrite=%b PCEn=%b want 0/0", IRWrite, PCEn);
        end
        tick();
        tests++;
        if (State !== 4'd0) begin fails++; $display("FAIL stall_hold: got %0d want 0", State); end
        MemReady = 1'b1;
        #1;
        tests++;
        if (IRWrite !== 1'b1 || PCEn !== 1'b1) begin
            fails++; $display("FAIL fetch_ready_ctrl: IRWrite=%b PCEn=%b want 1/1", IRWrite, PCEn);
        end
        tick();
        tests++;
        if (State !== 4'd1 || ALUSrcB !== 2'b11 || ALUControl !== 4'b0010) begin
            fails++; $display("FAIL decode_ctrl: State=%0d ALUSrcB=%b ALUControl=%b want 1/11/0010", State, ALUSrcB, ALUControl);
        end
        tick();
        tests++;
        if (State !== 4'd9 || PCEn !== 1'b1 || PCSource !== 2'b10) begin
            fails++; $display("FAIL jump_ctrl: State=%0d PCEn=%b PCSource=%b want 9/1/10", State, PCEn, PCSource);
        end
        tick();
        exp_ret++;
        tests++;
        if (State !== 4'd0 || InstrRetired !== exp_ret) begin
            fails++; $display("FAIL jump_retire: State=%0d count=%0d want 0/%0d", State, InstrRetired, exp_ret);
        end
    endtask

    task automatic test_rtype();
        logic [5:0] fn_v [8];
        logic [3:0] ac_v [8];
        fn_v = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000, 6'b000010, 6'b111111};
        ac_v = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b1000, 4'b1001, 4'b1111};
        for (int i = 0; i < 8; i++) begin
            Opcode   = 6'b000000;
            funct    = fn_v[i];
            MemReady = 1'b1;
            tick();
            tests++;
            if (State !== 4'd1) begin fails++; $display("FAIL rtype%0d_decode: State=%0d want 1", i, State); end
            MemReady = 1'b0;
            tick();
            tests++;
            if (State !== 4'd6 || ALUOp !== 2'b10 || ALUSrcA !== 1'b1 || ALUControl !== ac_v[i]) begin
                fails++; $display("FAIL rtype%0d_exec: State=%0d ALUOp=%b ALUControl=%b want 6/10/%b", i, State, ALUOp, ALUControl, ac_v[i]);
            end
            tests++;
            if (ALUControl4 !== {2'b00, ac_v[i]}) begin
                fails++; $display("FAIL rtype%0d_zext: got %b want %b", i, ALUControl4, {2'b00, ac_v[i]});
            end
            tick();
            tests++;
            if (State !== 4'd7 || RegWrite !== 1'b1 || RegDst !== 1'b1 || MemtoReg !== 1'b0) begin
                fails++; $display("FAIL rtype%0d_rwb: State=%0d RegWrite=%b RegDst=%b want 7/1/1", i, State, RegWrite, RegDst);
            end
            tick();
            exp_ret++;
            tests++;
            if (State !== 4'd0 || InstrRetired !== exp_ret) begin
                fails++; $display("FAIL rtype%0d_retire: State=%0d count=%0d want 0/%0d", i, State, InstrRetired, exp_ret);
            end
        end
    endtask

    task automatic test_lw_wait();
        Opcode   = 6'b100011;
        MemReady = 1'b1;
        tick();
        tick();
        tests++;
        if (State !== 4'd2 || ALUSrcA !== 1'b1 || ALUSrcB !== 2'b10) begin
            fails++; $display("FAIL lw_memadr: State=%0d ALUSrcA=%b ALUSrcB=%b want 2/1/10", State, ALUSrcA, ALUSrcB);
        end
        tick();
        MemReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests++;
            if (State !== 4'd3 || IorD !== 1'b1 || MemRead !== 1'b1) begin
                fails++; $display("FAIL lw_memrd%0d: State=%0d IorD=%b MemRead=%b want 3/1/1", i, State, IorD, MemRead);
            end
            if (i < 3) tick();
        end
        MemReady = 1'b1;
        tick();
        tests++;
        if (State !== 4'd4 || MemtoReg !== 1'b1 || RegWrite !== 1'b1 || RegDst !== 1'b0) begin
            fails++; $display("FAIL lw_memwb: State=%0d MemtoReg=%b RegWrite=%b want 4/1/1", State, MemtoReg, RegWrite);
        end
        tick();
        exp_ret++;
        tests++;
        if (State !== 4'd0 || InstrRetired !== exp_ret) begin
            fails++; $display("FAIL lw_retire: State=%0d count=%0d want 0/%0d", State, InstrRetired, exp_ret);
        end
    endtask

    task automatic test_branch();
        logic [5:0] op_v [3];
        logic       z_v  [3];
        logic       pe_v [3];
        op_v = '{6'b000101, 6'b000100, 6'b000100};
        z_v  = '{1'b0, 1'b0, 1'b1};
        pe_v = '{1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            Opcode   = op_v[i];
            Zero     = z_v[i];
            MemReady = 1'b1;
            tick();
            tick();
            tests++;
            if (State !== 4'd8 || PCEn !== pe_v[i] || PCSource !== 2'b01 || ALUControl !== 4'b0110) begin
                fails++; $display("FAIL branch%0d: State=%0d PCEn=%b PCSource=%b ALUControl=%b want 8/%b/01/0110", i, State, PCEn, PCSource, ALUControl, pe_v[i]);
            end
            Zero = ~Zero;
            #1;
            tests++;
            if (PCEn !== ~pe_v[i]) begin
                fails++; $display("FAIL branch%0d_comb: PCEn=%b want %b", i, PCEn, ~pe_v[i]);
            end
            tick();
            exp_ret++;
            tests++;
            if (State !== 4'd0 || InstrRetired !== exp_ret) begin
                fails++; $display("FAIL branch%0d_retire: State=%0d count=%0d want 0/%0d", i, State, InstrRetired, exp_ret);
            end
        end
        Zero = 1'b0;
    endtask

    task automatic test_addi();
        Opcode   = 6'b001000;
        MemReady = 1'b1;
        tick();
        tick();
        tests++;
        if (State !== 4'd10 || ALUSrcB !== 2'b10 || ALUSrcA !== 1'b1) begin
            fails++; $display("FAIL addi_ex: State=%0d ALUSrcB=%b want 10/10", State, ALUSrcB);
        end
        tick();
        tests++;
        if (State !== 4'd11 || RegWrite !== 1'b1 || RegDst !== 1'b0) begin
            fails++; $display("FAIL addi_wb: State=%0d RegWrite=%b RegDst=%b want 11/1/0", State, RegWrite, RegDst);
        end
        tick();
        exp_ret++;
        tests++;
        if (State !== 4'd0 || InstrRetired !== exp_ret) begin
            fails++; $display("FAIL addi_retire: State=%0d count=%0d want 0/%0d", State, InstrRetired, exp_ret);
        end
    endtask

    task automatic test_reset_memwr();
        Opcode   = 6'b101011;
        MemReady = 1'b1;
        tick();
        tick();
        tick();
        MemReady = 1'b0;
        tick();
        tests++;
        if (State !== 4'd5 || MemWrite !== 1'b1 || IorD !== 1'b1) begin
            fails++; $display("FAIL sw_memwr: State=%0d MemWrite=%b IorD=%b want 5/1/1", State, MemWrite, IorD);
        end
        #1 rst_n = 1'b0;
        #1;
        tests++;
        if (State !== 4'd0 || InstrRetired !== 16'd0 || MemWrite !== 1'b0) begin
            fails++; $display("FAIL async_reset: State=%0d count=%0d MemWrite=%b want 0/0/0", State, InstrRetired, MemWrite);
        end
        rst_n   = 1'b1;
        exp_ret = '0;
        MemReady = 1'b1;
        Opcode   = 6'b000010;
        tick();
        tests++;
        if (State !== 4'd1 || MemWrite !== 1'b0 || InstrRetired !== 16'd0) begin
            fails++; $display("FAIL post_reset: State=%0d MemWrite=%b count=%0d want 1/0/0", State, MemWrite, InstrRetired);
        end
        tick();
        tick();
        exp_ret++;
    endtask

    task automatic test_illegal();
        Opcode   = 6'b111111;
        MemReady = 1'b1;
        tick();
        tick();
`ifdef MCTRL_ILLEGAL_TRAP_EN
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (State !== 4'd12 || Illegal !== 1'b1 || MemRead !== 1'b0 || PCEn !== 1'b0 || ALUControl !== 4'd0) begin
                fails++; $display("FAIL trap%0d: State=%0d Illegal=%b MemRead=%b PCEn=%b want 12/1/0/0", i, State, Illegal, MemRead, PCEn);
            end
            tick();
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (State !== 4'd0 || Illegal !== 1'b0) begin
            fails++; $display("FAIL trap_reset: State=%0d Illegal=%b want 0/0", State, Illegal);
        end
        rst_n   = 1'b1;
        exp_ret = '0;
`else
        tests++;
        if (State !== 4'd0 || Illegal !== 1'b0 || InstrRetired !== exp_ret) begin
            fails++; $display("FAIL illegal_noop: State=%0d Illegal=%b count=%0d want 0/0/%0d", State, Illegal, InstrRetired, exp_ret);
        end
`endif
    endtask

    task automatic test_wrap();
        rst_n = 1'b0;
        #2;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 15; i++) run_jump();
        tests++;
        if (InstrRetired4 !== 4'd15) begin fails++; $display("FAIL wrap_15: got %0d want 15", InstrRetired4); end
        run_jump();
        tests++;
        if (InstrRetired4 !== 4'd0) begin fails++; $display("FAIL wrap_16: got %0d want 0", InstrRetired4); end
        tests++;
        if (InstrRetired !== 16'd16) begin fails++; $display("FAIL wide_16: got %0d want 16", InstrRetired); end
    endtask

    initial begin
        test_reset();
        test_fetch_stall();
        test_rtype();
        test_lw_wait();
        test_branch();
        test_addi();
        test_reset_memwr();
        test_illegal();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter ALUCTRL_W, default 4: width of ALUControl; values above 4 SHALL zero-extend the 4-bit codes.
REQ-002 Parameter CNT_W, default 16: width of the InstrRetired counter.
REQ-003 Ports, in order:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- Opcode, input, 6: instruction opcode, sampled from the IR.
- funct, input, 6: R-type function field.
- Zero, input, 1: ALU zero flag.
- MemReady, input, 1: memory completes the current access this cycle.
- IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, PCEn: output, 1 each: datapath controls.
- ALUSrcB, ALUOp, PCSource: output, 2 each.
- ALUControl, output, ALUCTRL_W.
- State, output, 4: current FSM state.
- InstrRetired, output, CNT_W.
- Illegal, output, 1.

Function
REQ-004 States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11, TRAP=12.
REQ-005 Outputs SHALL be Moore decodes of State, except IRWrite, PCEn and the branch condition; any control not listed for a state SHALL be 0.
REQ-006 FETCH: MemRead=1, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite=PCEn=MemReady; the FSM SHALL stay in FETCH while MemReady=0 and move to DECODE when MemReady=1.
REQ-007 DECODE: ALUSrcB=11, ALUOp=00. Next state by Opcode: 100011 or 101011 -> MEMADR; 000000 -> EXEC; 000100 or 000101 -> BRANCH; 001000 -> ADDIEX; 000010 -> JUMP; any other opcode -> see REQ-015.
REQ-008 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next state MEMRD for LW, MEMWR for SW.
REQ-009 MEMRD: IorD=1, MemRead=1; holds until MemReady=1, then goes to MEMWB. MEMWB: RegWrite=1, MemtoReg=1, RegDst=0; then FETCH.
REQ-010 MEMWR: IorD=1, MemWrite=1; holds until MemReady=1, then goes to FETCH.
REQ-011 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10; then RWB. RWB: RegWrite=1, RegDst=1; then FETCH.
REQ-012 BRANCH: ALUSrcA=1, ALUOp=01, PCSource=01. PCEn=Zero for BEQ and ~Zero for BNE, evaluated combinationally; then FETCH.
REQ-013 JUMP: PCSource=10, PCEn=1; then FETCH. ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00; then ADDIWB. ADDIWB: RegWrite=1, RegDst=0; then FETCH.
REQ-014 ALUControl, 4-bit codes:
- ALUOp=00 -> 0010; ALUOp=01 -> 0110.
- ALUOp=10 by funct: 100000/100001 -> 0010; 100010/100011 -> 0110; 100100 -> 0000; 100101 -> 0001; 101010 -> 0111; 000000 -> 1000; 000010 -> 1001; other -> 1111.
- ALUOp=11 -> 1111.
REQ-015 Illegal opcode in DECODE without MCTRL_ILLEGAL_TRAP_EN: the FSM SHALL return to FETCH (no-op) and SHALL NOT increment InstrRetired.
REQ-016 InstrRetired SHALL increment by 1, wrapping modulo 2^CNT_W, on every transition into FETCH from MEMWB, MEMWR, RWB, BRANCH, JUMP or ADDIWB.
REQ-017 A MemReady pulse outside FETCH, MEMRD and MEMWR SHALL be ignored.

Reset
REQ-018 When rst_n=0, asynchronously: State=FETCH, InstrRetired=0, Illegal=0.
REQ-019 Reset SHALL take effect in any state, including mid-wait in MEMRD or MEMWR, with no partial write completed afterward; the first post-reset edge begins in FETCH.

Configuration
REQ-020 Macro MCTRL_ILLEGAL_TRAP_EN:
- Defined: an illegal opcode in DECODE -> TRAP. TRAP sets Illegal=1, drives all other controls to 0, and is exited only by reset.
- Undefined: TRAP is unreachable, Illegal is tied to 0, and REQ-015 applies.

Structure
REQ-021 A shared package mctrl_pkg SHALL hold the state encodings, opcode and funct constants, and the ALUControl codes.
REQ-022 ALU-control decoding SHALL be one combinational sub-module, alu_decoder (ALUOp, funct -> ALUControl); the FSM, PCEn logic and counter SHALL live in multicycle_control.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- R-type ADD (Opcode 000000, funct 100000), MemReady=1 throughout -> states 0,1,6,7,0; ALUControl=0010 in EXEC; RegWrite=1 with RegDst=1 in RWB; InstrRetired 0->1.
- LW with MemReady held 0 for 3 cycles in MEMRD -> State=3 for 4 cycles, then MEMWB with MemtoReg=1 and RegWrite=1; 5 states plus 3 waits.
- BNE with Zero=0 -> PCEn=1 and PCSource=01 in BRANCH; BEQ with Zero=0 -> PCEn=0.
- J (000010) -> JUMP with PCEn=1 and PCSource=10; next state FETCH.
- Opcode 111111 -> with the macro: State=12 and Illegal=1 until rst_n falls; without it: back to FETCH with InstrRetired unchanged.
- rst_n asserted while in MEMWR -> State=0 and InstrRetired=0 immediately, with no clock edge; plus CNT_W=4 with 16 instructions -> InstrRetired wraps to 0.
